// File: rtl/bcdu_arbiter_if.sv
// Requester/bcdu signal bundle for bcdu_arbiter.
// The slave modport is the arbiter's side; the master modport is the requesters and bcdu side.
interface bcdu_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int INSTR_WIDTH = 16,
  parameter int FLAGS_WIDTH = 5
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             i_req_valid;
  logic [NUM_REQ*INSTR_WIDTH-1:0] i_req_instr;
  logic [NUM_REQ-1:0]             i_req_lock;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic [NUM_REQ-1:0]             o_rsp_valid;
  logic [3:0]                     o_rsp_digit;
  logic [FLAGS_WIDTH-1:0]         o_rsp_flags;
  logic [OW-1:0]                  o_owner;
  logic                           o_locked;
  logic                           o_bcdu_valid;
  logic [INSTR_WIDTH-1:0]         o_bcdu_instr;
  logic                           i_bcdu_ready;
  logic [3:0]                     i_bcdu_digit;
  logic [FLAGS_WIDTH-1:0]         i_bcdu_flags;

  modport slave (
    input  i_req_valid, i_req_instr, i_req_lock, i_bcdu_ready, i_bcdu_digit, i_bcdu_flags,
    output o_req_ready, o_rsp_valid, o_rsp_digit, o_rsp_flags, o_owner, o_locked,
           o_bcdu_valid, o_bcdu_instr
  );

  modport master (
    output i_req_valid, i_req_instr, i_req_lock, i_bcdu_ready, i_bcdu_digit, i_bcdu_flags,
    input  o_req_ready, o_rsp_valid, o_rsp_digit, o_rsp_flags, o_owner, o_locked,
           o_bcdu_valid, o_bcdu_instr
  );
endinterface

// File: rtl/bcdu_arbiter.sv
// Round-robin arbiter sharing one bcdu among NUM_REQ requesters, one instruction in flight, with locking.
// Optional lock timeout when BCDU_ARB_LOCK_TMO_EN is defined.
//
// state  | meaning
// S_IDLE  | grant to round-robin winner (or lock owner only)
// S_ISSUE | present latched instruction to bcdu until it accepts
// S_BUSY  | wait minimum latency, then capture result on bcdu ready
// S_RESP  | one-cycle response pulse to the issuing requester
module bcdu_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int INSTR_WIDTH = 16,
  parameter int FLAGS_WIDTH = 5,
  parameter int MIN_LAT     = 2,
  parameter int LOCK_TMO    = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bcdu_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int LW = (MIN_LAT > 1) ? $clog2(MIN_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [OW-1:0]          rr_q, owner_q, win_idx, cand;
  logic                   locked_q, win_vld, accept, done;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [LW-1:0]          lat_q;
  logic [3:0]             digit_q;
  logic [FLAGS_WIDTH-1:0] flags_q;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] v);
    return (v == OW'(NUM_REQ-1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] v);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  // A locked owner is the only eligible requester, so it can never be overtaken.
  always_comb begin
    win_vld = 1'b0;
    win_idx = owner_q;
    cand    = '0;
    if (locked_q) begin
      win_vld = bus.i_req_valid[owner_q];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = OW'((int'(rr_q) + k) % NUM_REQ);
        if (!win_vld && bus.i_req_valid[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  assign accept = (state_q == S_IDLE) && win_vld;
  assign done   = (state_q == S_BUSY) && (lat_q == '0) && bus.i_bcdu_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.o_req_ready  = '0;
    bus.o_rsp_valid  = '0;
    bus.o_bcdu_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          bus.o_req_ready = onehot(win_idx);
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.o_bcdu_valid = 1'b1;
        if (bus.i_bcdu_ready) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (done) state_d = S_RESP;
      end
      S_RESP: begin
        bus.o_rsp_valid = onehot(owner_q);
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_bcdu_instr = instr_q;
  assign bus.o_rsp_digit  = digit_q;
  assign bus.o_rsp_flags  = flags_q;
  assign bus.o_owner      = owner_q;
  assign bus.o_locked     = locked_q;

`ifdef BCDU_ARB_LOCK_TMO_EN
  localparam int TW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
  logic [TW-1:0] tmo_q;
  logic          owner_silent;
  assign owner_silent = (state_q == S_IDLE) && locked_q && !bus.i_req_valid[owner_q];
`else
  logic unused_lock_tmo;
  assign unused_lock_tmo = ^LOCK_TMO;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q     <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      instr_q  <= '0;
      lat_q    <= '0;
      digit_q  <= 4'hF;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        instr_q  <= bus.i_req_instr[win_idx*INSTR_WIDTH +: INSTR_WIDTH];
        owner_q  <= win_idx;
        locked_q <= bus.i_req_lock[win_idx];
        if (!bus.i_req_lock[win_idx]) rr_q <= next_idx(win_idx);
      end
      // Down-counter: reaching zero means MIN_LAT-1 busy cycles have elapsed.
      if (state_q == S_ISSUE && bus.i_bcdu_ready) lat_q <= LW'(MIN_LAT-1);
      else if (state_q == S_BUSY && lat_q != '0)  lat_q <= lat_q - 1'b1;
      if (done) begin
        digit_q <= bus.i_bcdu_digit;
        flags_q <= bus.i_bcdu_flags;
      end
`ifdef BCDU_ARB_LOCK_TMO_EN
      if (owner_silent) begin
        if (tmo_q == '0) begin
          locked_q <= 1'b0;
          rr_q     <= next_idx(owner_q);
        end
      end
`endif
    end
  end

`ifdef BCDU_ARB_LOCK_TMO_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || accept)                 tmo_q <= TW'(LOCK_TMO-1);
    else if (owner_silent && tmo_q == '0) tmo_q <= TW'(LOCK_TMO-1);
    else if (owner_silent)               tmo_q <= tmo_q - 1'b1;
  end
`endif
endmodule
